// File: rtl/ram_arbiter_pkg.sv
// Shared constants and types for the two-port RAM arbiter: FSM encodings,
// default bus widths and the latched-transaction record.
package ram_arbiter_pkg;

   localparam int ARB_DATA_W = 8;
   localparam int ARB_ADDR_W = 8;

   localparam logic [1:0] ARB_IDLE  = 2'd0;
   localparam logic [1:0] ARB_ISSUE = 2'd1;
   localparam logic [1:0] ARB_RDATA = 2'd2;

   typedef struct packed {
      logic port;
      logic we;
   } arb_txn_t;

   function automatic logic [1:0] port_onehot(input logic port);
      return port ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/ram_arbiter_rr_pick2.sv
// Combinational two-way round-robin pick: a lone request wins outright,
// a tie goes to the port that was not granted last.
module rr_pick2 (
   input  logic [1:0] req,
   input  logic       last,
   output logic       winner,
   output logic       any
);

   assign any    = |req;
   assign winner = (req == 2'b11) ? ~last : req[1];

endmodule

// File: rtl/ram_arbiter.sv
// Shares the single-ported data RAM between the control unit (port 0) and a
// loader/debug port (port 1). Optional bus lock: define RAM_ARB_LOCK_EN.
module ram_arbiter
   import ram_arbiter_pkg::*;
#(
   parameter int DATA_W = ARB_DATA_W,
   parameter int ADDR_W = ARB_ADDR_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req0,
   input  logic              req1,
   input  logic              we0,
   input  logic              we1,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata0,
   input  logic [DATA_W-1:0] wdata1,
`ifdef RAM_ARB_LOCK_EN
   input  logic              lock0,
   input  logic              lock1,
`endif
   output logic              ack0,
   output logic              ack1,
   output logic              rvalid0,
   output logic              rvalid1,
   output logic [DATA_W-1:0] rdata0,
   output logic [DATA_W-1:0] rdata1,
   output logic              ram_en,
   output logic              ram_write,
   output logic              ram_read,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   input  logic [DATA_W-1:0] ram_rdata
);

   // Handshake: a requester holds reqN/weN/addrN/wdataN until it sees the
   // one-cycle ackN, then drops reqN; a req still high at the next IDLE is
   // a fresh access. Reads complete later with a one-cycle rvalidN.

   logic [1:0]        state;
   logic              last_grant;
   arb_txn_t          cur;
   logic [1:0]        req_eff;
   logic              locked_grant;
   logic              pick;
   logic              pick_any;
   logic              sel_we;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_wdata;

   rr_pick2 u_pick (
      .req    (req_eff),
      .last   (last_grant),
      .winner (pick),
      .any    (pick_any)
   );

`ifdef RAM_ARB_LOCK_EN
   logic lock_hold;
   logic lock_live;

   // cur.port still names the previous winner while we sit in IDLE.
   assign lock_live    = lock_hold && (cur.port ? lock1 : lock0);
   assign req_eff      = lock_live ? ({req1, req0} & port_onehot(cur.port)) : {req1, req0};
   assign locked_grant = lock_live;

   always_ff @(posedge clk) begin
      if (!reset) begin
         lock_hold <= 1'b0;
      end else if ((state == ARB_ISSUE && cur.we) || state == ARB_RDATA) begin
         lock_hold <= cur.port ? lock1 : lock0;
      end
   end
`else
   assign req_eff      = {req1, req0};
   assign locked_grant = 1'b0;
`endif

   assign sel_we    = pick ? we1    : we0;
   assign sel_addr  = pick ? addr1  : addr0;
   assign sel_wdata = pick ? wdata1 : wdata0;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state      <= ARB_IDLE;
         last_grant <= 1'b1;
         cur        <= '0;
         ack0       <= 1'b0;
         ack1       <= 1'b0;
         rvalid0    <= 1'b0;
         rvalid1    <= 1'b0;
         rdata0     <= '0;
         rdata1     <= '0;
         ram_en     <= 1'b0;
         ram_write  <= 1'b0;
         ram_read   <= 1'b0;
         ram_addr   <= '0;
         ram_wdata  <= '0;
      end else begin
         ack0    <= 1'b0;
         ack1    <= 1'b0;
         rvalid0 <= 1'b0;
         rvalid1 <= 1'b0;
         case (state)
            ARB_IDLE: begin
               if (pick_any) begin
                  cur.port     <= pick;
                  cur.we       <= sel_we;
                  ram_en       <= 1'b1;
                  ram_write    <= sel_we;
                  ram_read     <= !sel_we;
                  ram_addr     <= sel_addr;
                  ram_wdata    <= sel_wdata;
                  {ack1, ack0} <= port_onehot(pick);
                  // A locked grant must not disturb round-robin history.
                  if (!locked_grant) begin
                     last_grant <= pick;
                  end
                  state <= ARB_ISSUE;
               end
            end
            ARB_ISSUE: begin
               ram_en    <= 1'b0;
               ram_write <= 1'b0;
               ram_read  <= 1'b0;
               state     <= cur.we ? ARB_IDLE : ARB_RDATA;
            end
            ARB_RDATA: begin
               if (cur.port) begin
                  rdata1  <= ram_rdata;
                  rvalid1 <= 1'b1;
               end else begin
                  rdata0  <= ram_rdata;
                  rvalid0 <= 1'b1;
               end
               state <= ARB_IDLE;
            end
            default: state <= ARB_IDLE;
         endcase
      end
   end

endmodule
